// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown sequencer driving a 4-digit BCD cascade (MM:SS).
// Optional quick start (QUICK_TIME load on start) enabled by QUICK_START_EN.
module microwave_timer_ctrl #(
  parameter int          BEEP_TICKS = 3,
  parameter logic [15:0] QUICK_TIME = 16'h0030
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        tick_1hz,
  input  logic        set_time,
  input  logic [15:0] time_in,
  input  logic        start,
  input  logic        cancel,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [15:0] timer_din,
  output logic        timer_load,
  output logic        timer_stop,
  output logic        timer_clear,
  output logic        mag_on,
  output logic        beep,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BW = $clog2(BEEP_TICKS + 1);

`ifdef QUICK_START_EN
  localparam bit QUICK_EN = 1'b1;
`else
  localparam bit QUICK_EN = 1'b0;
`endif

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_nx;
  logic          load;
  logic          run;
  logic          clr;
  logic          quick;
  logic          has_time;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bcnt_nx  = '0;
    load     = 1'b0;
    run      = 1'b0;
    clr      = 1'b0;
    quick    = 1'b0;
    has_time = (time_in != 16'h0000);
    case (state)
      IDLE: begin
        if (cancel) begin
          state_nx = IDLE;
        end else if (QUICK_EN && start && door_closed) begin
          quick    = 1'b1;
          load     = 1'b1;
          state_nx = COOK;
        end else if (set_time && has_time) begin
          load     = 1'b1;
          state_nx = READY;
        end
      end
      READY: begin
        if (cancel) begin
          clr      = 1'b1;
          state_nx = IDLE;
        end else if (start && door_closed) begin
          state_nx = COOK;
        end else if (set_time && has_time) begin
          load = 1'b1;
        end
      end
      COOK: begin
        // zero check first so the cascade never borrows past 00:00
        if (timer_zero) begin
          state_nx = DONE;
        end else if (cancel || !door_closed) begin
          state_nx = PAUSE;
        end else if (tick_1hz) begin
          run = 1'b1;
        end
      end
      PAUSE: begin
        if (cancel) begin
          clr      = 1'b1;
          state_nx = IDLE;
        end else if (start && door_closed) begin
          state_nx = COOK;
        end
      end
      DONE: begin
        bcnt_nx = bcnt;
        if (cancel) begin
          state_nx = IDLE;
        end else if (start) begin
          if (QUICK_EN && door_closed) begin
            quick    = 1'b1;
            load     = 1'b1;
            state_nx = COOK;
          end else begin
            state_nx = IDLE;
          end
        end else if (tick_1hz) begin
          if (bcnt == BW'(BEEP_TICKS - 1)) begin
            state_nx = IDLE;
          end else begin
            bcnt_nx = bcnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // reset forces the cascade into clear/hold regardless of inputs
  assign timer_load  = load & ~clear;
  assign timer_stop  = clear | ~(load | run);
  assign timer_clear = clear | clr;
  assign timer_din   = clear ? 16'h0000 :
                       quick ? QUICK_TIME : time_in;
  assign mag_on      = (state == COOK);
  assign beep        = (state == DONE);
  assign state_o     = state;

endmodule
